// File: rtl/ysyx_22050612_pkg.sv
// Shared types for the RV64M multiply/divide unit.
// Holds funct3 op encodings, FSM states and the W-variant iteration count.
// No logic; imported by the MDU top level.
package ysyx_22050612_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  localparam int W_ITER = 32;

endpackage

// File: rtl/ysyx_22050612_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the outputs.
module ysyx_22050612_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            dvd_bit_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_bit_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // The partial remainder is always below the divisor, so the shifted value
  // fits XLEN+1 bits and the top bit of the trial difference is its sign.
  always_comb begin
    shifted = {rem_i, dvd_bit_i};
    trial   = shifted - {1'b0, divisor_i};
    q_bit_o = ~trial[XLEN];
    rem_o   = q_bit_o ? trial[XLEN-1:0] : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/ysyx_22050612_mdu.sv
// RV64M multiply/divide unit: magnitude shift-add multiply and restoring divide, one bit per cycle.
// Latency: XLEN+1 cycles full width, 33 for W-variants, 1 for divide-by-zero / signed overflow.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE; flush kills any state.
module ysyx_22050612_mdu
  import ysyx_22050612_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int DW = 2 * XLEN;
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0]   K_FULL   = CW'(XLEN);
  localparam logic [CW-1:0]   K_WORD   = CW'(W_ITER);
  localparam logic [XLEN-1:0] MIN_FULL = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_WORD = ~XLEN'(32'h7FFF_FFFF);

  mdu_state_e      state_q, state_d;
  mdu_op_e         op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            word_q, word_d;
  logic            neg_q, neg_d;     // product / quotient sign
  logic            rneg_q, rneg_d;   // remainder sign (follows dividend)
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] a_q, a_d;         // multiplier, or dividend shifting into quotient
  logic [DW-1:0]   b_q, b_d;         // multiplicand (shifts left), or divisor in low half
  logic [DW-1:0]   acc_q, acc_d;     // product, or partial remainder in low half
  logic [XLEN-1:0] result_q, result_d;

  mdu_op_e         op_e;
  logic            word_eff, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;
  logic [CW-1:0]   k_in, k_q;
  logic [DW-1:0]   prod;
  logic [XLEN-1:0] quo, rem, raw, fin;
  logic [XLEN-1:0] step_rem;
  logic            step_q;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign rd_out    = rd_q;

  ysyx_22050612_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_i     (acc_q[XLEN-1:0]),
    .divisor_i (b_q[XLEN-1:0]),
    .dvd_bit_i (a_q[XLEN-1]),
    .rem_o     (step_rem),
    .q_bit_o   (step_q)
  );

  // Operand preparation: word extension, magnitudes, special-case detection.
  always_comb begin
    op_e     = mdu_op_e'(op);
    word_eff = (XLEN > 32) && word && !(op_e inside {OP_MULH, OP_MULHSU, OP_MULHU});
    a_sgn    = op_e inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_sgn    = op_e inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    a_ext    = word_eff ? (a_sgn ? XLEN'($signed(src1[31:0])) : XLEN'(src1[31:0])) : src1;
    b_ext    = word_eff ? (b_sgn ? XLEN'($signed(src2[31:0])) : XLEN'(src2[31:0])) : src2;
    a_neg    = a_sgn & a_ext[XLEN-1];
    b_neg    = b_sgn & b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    div_zero = op[2] && (b_ext == '0);
    div_ovf  = op[2] && !op[0] && (b_ext == '1) && (a_ext == (word_eff ? MIN_WORD : MIN_FULL));
    k_in     = word_eff ? K_WORD : K_FULL;
    k_q      = word_q ? K_WORD : K_FULL;
  end

  // Sign fixup and result selection, used on the cycle after the last iteration.
  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    quo  = neg_q ? -a_q : a_q;
    rem  = rneg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    if (state_q == ST_DIV) begin
      raw = (op_q inside {OP_REM, OP_REMU}) ? rem : quo;
    end else begin
      raw = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[DW-1:XLEN];
    end
    fin = word_q ? XLEN'($signed(raw[31:0])) : raw;
  end

  // Next-state logic: accept, iterate, finish, hand off; flush overrides all.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    rd_d     = rd_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && !flush) begin
          op_d   = op_e;
          word_d = word_eff;
          rd_d   = rd_in;
          cnt_d  = '0;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          b_d    = DW'(b_mag);
          acc_d  = '0;
          if (op[2]) begin
            state_d = ST_DIV;
            // W-variant dividends are left-aligned so the first step sees bit 31.
            a_d = word_eff ? (a_mag << (XLEN - W_ITER)) : a_mag;
            // Special cases preload the final quotient/remainder and skip the
            // iterations by starting the counter at its terminal value.
            if (div_zero || div_ovf) begin
              cnt_d  = k_in;
              neg_d  = 1'b0;
              rneg_d = 1'b0;
              a_d    = div_zero ? '1 : a_ext;
              acc_d  = div_zero ? DW'(a_ext) : '0;
            end
          end else begin
            state_d = ST_MUL;
            a_d     = a_mag;
          end
        end
      end
      ST_MUL: begin
        if (cnt_q == k_q) begin
          result_d = fin;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (a_q[0]) acc_d = acc_q + b_q;
          b_d = b_q << 1;
          a_d = a_q >> 1;
        end
      end
      ST_DIV: begin
        if (cnt_q == k_q) begin
          result_d = fin;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          acc_d = DW'(step_rem);
          a_d   = {a_q[XLEN-2:0], step_q};
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      rd_q     <= rd_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22050612_mdu.sv
// Directed and randomized bench for the MDU with an expected-result queue.
// Checks reset values, results, latency, backpressure hold, flush and reset kill.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ysyx_22050612_mdu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'd0;
  logic        word = 1'b0;
  logic [63:0] src1 = 64'd0;
  logic [63:0] src2 = 64'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;
  logic [4:0]  rd_out;

  int n_assert = 0;
  int n_fail   = 0;
  logic [68:0] exp_q[$];

  always #5 clk = ~clk;

  ysyx_22050612_mdu #(.XLEN(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .word      (word),
    .src1      (src1),
    .src2      (src2),
    .rd_in     (rd_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .rd_out    (rd_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Architectural RV64M result.
  function automatic logic [63:0] model(input logic [2:0] o, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic [63:0]  x, y, q, rm, r;
    logic         sg;
    r = 64'd0;
    case (o)
      3'd0: begin p = {64'd0, a} * {64'd0, b}; r = w ? sx32(p[31:0]) : p[63:0]; end
      3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
      3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; r = p[127:64]; end
      3'd3: begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
      default: begin
        sg = !o[0];
        x = w ? (sg ? sx32(a[31:0]) : {32'd0, a[31:0]}) : a;
        y = w ? (sg ? sx32(b[31:0]) : {32'd0, b[31:0]}) : b;
        if (y == 64'd0) begin
          q = '1; rm = x;
        end else if (sg && y == '1 && x == 64'h8000_0000_0000_0000) begin
          q = x; rm = 64'd0;
        end else if (sg) begin
          q = $signed(x) / $signed(y); rm = $signed(x) % $signed(y);
        end else begin
          q = x / y; rm = x % y;
        end
        r = o[1] ? rm : q;
        if (w) r = sx32(r[31:0]);
      end
    endcase
    return r;
  endfunction

  // Cycles from the accept edge to out_valid being visible.
  function automatic int exp_latency(input logic [2:0] o, input logic w,
                                     input logic [63:0] a, input logic [63:0] b);
    logic        we, sg;
    logic [63:0] x, y;
    int          l;
    we = w && !(o inside {3'd1, 3'd2, 3'd3});
    l  = we ? 33 : 65;
    if (o[2]) begin
      sg = !o[0];
      x = we ? (sg ? sx32(a[31:0]) : {32'd0, a[31:0]}) : a;
      y = we ? (sg ? sx32(b[31:0]) : {32'd0, b[31:0]}) : b;
      if (y == 64'd0) l = 1;
      if (sg && y == '1 && x == (we ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) l = 1;
    end
    return l;
  endfunction

  task automatic run_op(input logic [2:0] o, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd,
                        input logic [63:0] exp_res, input int hold);
    logic [68:0] ent;
    int lat, elat;
    elat = exp_latency(o, w, a, b);
    @(negedge clk);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    op = o; word = w; src1 = a; src2 = b; rd_in = rd; in_valid = 1'b1;
    exp_q.push_back({exp_res, rd});
    @(negedge clk);
    in_valid = 1'b0;
    src1 = 64'hA5A5_5A5A_DEAD_BEEF;
    src2 = 64'h0123_4567_89AB_CDEF;
    rd_in = ~rd;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(elat));
    ent = exp_q.pop_front();
    chk("result", result, ent[68:5]);
    chk("rd_out", 64'(rd_out), 64'(ent[4:0]));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_result", result, ent[68:5]);
      chk("hold_rd", 64'(rd_out), 64'(ent[4:0]));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("in_ready_during_hs", 64'(in_ready), 64'd0);
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_hs", 64'(in_ready), 64'd1);
    chk("valid_after_hs", 64'(out_valid), 64'd0);
  endtask

  // Start a full-width DIV, then kill it at iteration 10 by flush or reset.
  task automatic kill_op(input logic use_rst);
    int seen;
    seen = 0;
    @(negedge clk);
    op = 3'd4; word = 1'b0; src1 = 64'd123456789; src2 = 64'd77; rd_in = 5'd9; in_valid = 1'b1;
    exp_q.push_back({model(3'd4, 1'b0, 64'd123456789, 64'd77), 5'd9});
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    if (use_rst) begin
      rst_n = 1'b0;
      #1;
      chk("rst_kill_valid", 64'(out_valid), 64'd0);
      chk("rst_kill_in_ready", 64'(in_ready), 64'd1);
      chk("rst_kill_result", result, 64'd0);
      chk("rst_kill_rd", 64'(rd_out), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      chk("flush_valid", 64'(out_valid), 64'd0);
    end
    void'(exp_q.pop_back());
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("no_result_after_kill", 64'(seen), 64'd0);
  endtask

  initial begin
    logic [2:0]  ro;
    logic        rw;
    logic [63:0] ra, rb;
    logic [4:0]  rrd;

    repeat (2) @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_result", result, 64'd0);
    chk("reset_rd_out", 64'(rd_out), 64'd0);
    rst_n = 1'b1;

    run_op(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, 0);
    run_op(3'd3, 1'b0, '1, '1, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    run_op(3'd4, 1'b0, 64'd100, 64'd0, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op(3'd6, 1'b0, 64'd100, 64'd0, 5'd8, 64'd100, 0);
    run_op(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd10, 64'h8000_0000_0000_0000, 0);
    run_op(3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd11, 64'd0, 0);
    run_op(3'd4, 1'b1, 64'hDEAD_BEEF_FFFF_FFF9, 64'd2, 5'd12, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    run_op(3'd6, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 5'd13, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op(3'd1, 1'b0, 64'h4000_0000_0000_0000, 64'd4, 5'd0, 64'd1, 5);

    // flush wins over a same-cycle request
    @(negedge clk);
    op = 3'd0; word = 1'b0; src1 = 64'd3; src2 = 64'd4; rd_in = 5'd1;
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_blocks_accept", 64'(in_ready), 64'd1);

    kill_op(1'b0);
    run_op(3'd5, 1'b0, 64'd1000, 64'd7, 5'd14, 64'd142, 0);
    kill_op(1'b1);
    run_op(3'd7, 1'b0, 64'd1000, 64'd7, 5'd15, 64'd6, 0);

    for (int t = 0; t < 16; t++) begin
      ro  = 3'($urandom_range(0, 7));
      rw  = 1'($urandom_range(0, 1));
      rrd = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0: ra = 64'h8000_0000_0000_0000;
        1: ra = -64'($urandom_range(1, 50));
        default: ra = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 5))
        0: rb = 64'd0;
        1: rb = '1;
        2: rb = 64'($urandom_range(1, 20));
        default: rb = {$urandom, $urandom};
      endcase
      run_op(ro, rw, ra, rb, rrd, model(ro, rw, ra, rb), 0);
    end

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
